// File: rtl/tri_addrcmp_bank.sv
// Multi-entry watch-address compare bank: 2-stage compare pipeline with
// per-entry ignore-count granule, priority index, multi-hit and saturating hit counters.
module tri_addrcmp_bank #(
    parameter int WIDTH     = 36,
    parameter int ENTRIES   = 4,
    parameter int IDX_WIDTH = 2,
    parameter int IGN_WIDTH = 3,
    parameter int MAX_IGN   = 6,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 wr_val,
    input  logic [IDX_WIDTH-1:0] wr_idx,
    input  logic [0:WIDTH-1]     wr_addr,
    input  logic [IGN_WIDTH-1:0] wr_ign,
    input  logic                 wr_ent_val,
    input  logic                 cmp_val,
    input  logic [0:WIDTH-1]     cmp_addr,
    input  logic                 cmp_flush,
    input  logic                 cnt_clr,
    input  logic [IDX_WIDTH-1:0] cnt_rd_idx,
    output logic [CNT_WIDTH-1:0] cnt_rd_data,
    output logic [ENTRIES-1:0]   entry_vld,
    output logic                 hit_val,
    output logic [ENTRIES-1:0]   hit_vec,
    output logic [IDX_WIDTH-1:0] hit_idx,
    output logic                 multi_hit
);

    localparam int NGRP = (WIDTH + 7) / 8;
    localparam int PADW = NGRP * 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [IGN_WIDTH-1:0] IGN_CLAMP = IGN_WIDTH'(MAX_IGN);

    logic [IGN_WIDTH-1:0] wr_ign_clamped;
    logic [ENTRIES-1:0]   vld_vec;
    logic [ENTRIES-1:0]   hit_d;
    logic [CNT_WIDTH-1:0] cnt_arr [ENTRIES];
    logic [IDX_WIDTH-1:0] idx_d;
    logic                 multi_d;
    logic                 s1_val_q;
    logic                 s2_load;
    logic                 hit_val_q;
    logic [ENTRIES-1:0]   hit_vec_q;
    logic [IDX_WIDTH-1:0] hit_idx_q;
    logic                 multi_hit_q;

    assign wr_ign_clamped = (wr_ign > IGN_CLAMP) ? IGN_CLAMP : wr_ign;
    assign s2_load        = s1_val_q & ~cmp_flush;

    genvar gi, gw, gg;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_ent
            logic                 ent_vld_q;
            logic [0:WIDTH-1]     ent_addr_q;
            logic [IGN_WIDTH-1:0] ent_ign_q;
            logic [CNT_WIDTH-1:0] ent_cnt_q;
            logic [NGRP-1:0]      grp_eq_q;
            logic                 s1_vld_q;
            logic [PADW-1:0]      diff;
            logic [NGRP-1:0]      grp_eq_d;
            logic                 wr_sel;

            assign wr_sel = wr_val && (wr_idx == IDX_WIDTH'(gi));

            // diff is indexed by bit weight (0 = LSB); ignored low bits and padding read as equal
            for (gw = 0; gw < PADW; gw++) begin : g_bit
                if (gw < WIDTH) begin : g_real
                    assign diff[gw] = (cmp_addr[WIDTH-1-gw] ^ ent_addr_q[WIDTH-1-gw])
                                      & (int'(ent_ign_q) <= gw);
                end else begin : g_pad
                    assign diff[gw] = 1'b0;
                end
            end

            for (gg = 0; gg < NGRP; gg++) begin : g_grp
                assign grp_eq_d[gg] = ~|diff[gg*8 +: 8];
            end

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    ent_vld_q  <= 1'b0;
                    ent_addr_q <= '0;
                    ent_ign_q  <= '0;
                    ent_cnt_q  <= '0;
                    grp_eq_q   <= '0;
                    s1_vld_q   <= 1'b0;
                end else begin
                    if (wr_sel) begin
                        ent_vld_q  <= wr_ent_val;
                        ent_addr_q <= wr_addr;
                        ent_ign_q  <= wr_ign_clamped;
                    end
                    if (cmp_val) begin
                        grp_eq_q <= grp_eq_d;
                        s1_vld_q <= ent_vld_q;
                    end
                    if (cnt_clr || wr_sel) begin
                        ent_cnt_q <= '0;
                    end else if (hit_val_q && hit_vec_q[gi] && (ent_cnt_q != CNT_MAX)) begin
                        ent_cnt_q <= ent_cnt_q + 1'b1;
                    end
                end
            end

            assign vld_vec[gi] = ent_vld_q;
            assign cnt_arr[gi] = ent_cnt_q;
            assign hit_d[gi]   = s1_vld_q & (&grp_eq_q);
        end
    endgenerate

    always_comb begin
        idx_d = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hit_d[i]) idx_d = IDX_WIDTH'(i);
        end
        multi_d = |(hit_d & (hit_d - ENTRIES'(1)));
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1_val_q    <= 1'b0;
            hit_val_q   <= 1'b0;
            hit_vec_q   <= '0;
            hit_idx_q   <= '0;
            multi_hit_q <= 1'b0;
        end else begin
            s1_val_q  <= cmp_val & ~cmp_flush;
            hit_val_q <= s2_load;
            if (s2_load) begin
                hit_vec_q   <= hit_d;
                hit_idx_q   <= idx_d;
                multi_hit_q <= multi_d;
            end else begin
                hit_vec_q   <= '0;
                hit_idx_q   <= '0;
                multi_hit_q <= 1'b0;
            end
        end
    end

    assign entry_vld   = vld_vec;
    assign hit_val     = hit_val_q;
    assign hit_vec     = hit_vec_q;
    assign hit_idx     = hit_idx_q;
    assign multi_hit   = multi_hit_q;
    assign cnt_rd_data = (int'(cnt_rd_idx) < ENTRIES) ? cnt_arr[cnt_rd_idx] : '0;

endmodule
